// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready receiver among N senders.
// Optional transfer counter output xfer_cnt_o enabled by defining HS_ARB_CNT_EN.
module handshake_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_valid_i,
  input  logic [N*DW-1:0] s_data_i,
  output logic [N-1:0]    s_ready_o,
  output logic            m_valid_o,
  output logic [DW-1:0]   m_data_o,
  input  logic            m_ready_i,
  output logic [N-1:0]    grant_o,
  output logic            busy_o
`ifdef HS_ARB_CNT_EN
  , output logic [15:0]   xfer_cnt_o
`endif
);

  localparam int PW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic [DW-1:0] data_arr [N];
  logic [DW-1:0] data_mux;
  logic          g_valid;
  logic [PW-1:0] g_idx;
  logic          busy;
  logic          hs;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign data_arr[gi] = s_data_i[gi*DW +: DW];
    end
  endgenerate

  // Search starts one past ptr and wraps, so ptr itself has lowest priority.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req,
                                           input logic [PW-1:0] ptr);
    logic [N-1:0]  win;
    logic          found;
    logic [PW-1:0] idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [PW-1:0] oh2idx(input logic [N-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < N; i++) begin
      data_mux = data_mux | (data_arr[i] & {DW{grant_q[i]}});
    end
  end

  assign busy    = (state_q == BUSY);
  assign g_valid = |(s_valid_i & grant_q);
  assign g_idx   = oh2idx(grant_q);
  assign hs      = busy & g_valid & m_ready_i;

  assign m_valid_o = busy & g_valid;
  assign m_data_o  = busy ? data_mux : '0;
  assign s_ready_o = (busy & m_ready_i) ? grant_q : '0;
  assign grant_o   = grant_q;
  assign busy_o    = busy;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|s_valid_i) begin
          grant_d = rr_pick(s_valid_i, ptr_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!g_valid) begin
          // Sender withdrew before its handshake: drop the grant, keep ptr.
          grant_d = '0;
          state_d = IDLE;
        end else if (m_ready_i) begin
          // Searching from g wraps back to g last, so a sole requester keeps its grant.
          ptr_d   = g_idx;
          grant_d = rr_pick(s_valid_i, g_idx);
          if (grant_d == '0) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef HS_ARB_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q + {15'd0, hs};
  end

  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= '0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt_o = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench for handshake_rr_arbiter: directed scenarios plus random
// traffic compared against a transaction-level round-robin model.
module tb_handshake_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    s_valid_i;
  logic [N*DW-1:0] s_data_i;
  logic [N-1:0]    s_ready_o;
  logic            m_valid_o;
  logic [DW-1:0]   m_data_o;
  logic            m_ready_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;
`ifdef HS_ARB_CNT_EN
  logic [15:0]     xfer_cnt_o;
`endif

  handshake_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (s_valid_i),
    .s_data_i  (s_data_i),
    .s_ready_o (s_ready_o),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_ready_i (m_ready_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o)
`ifdef HS_ARB_CNT_EN
    , .xfer_cnt_o(xfer_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: either idle, or one sender index holds the grant; ptr is the last served sender.
  bit          mb;
  int          mg;
  int          mptr;
  int          mcnt;
  int          total_hs;
  bit          quiet;
  logic [N-1:0] last_hs;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int next_owner(input logic [N-1:0] req, input int after);
    for (int k = 1; k <= N; k++) begin
      if (req[(after + k) % N]) return (after + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input bit chk);
    logic [N-1:0]  eg, esr;
    logic          ev;
    logic [DW-1:0] ed;
    int            w;
    @(negedge clk);
    eg  = '0;
    esr = '0;
    ed  = '0;
    ev  = 1'b0;
    if (mb) begin
      eg[mg] = 1'b1;
      ev     = s_valid_i[mg];
      ed     = s_data_i[mg*DW +: DW];
      if (m_ready_i) esr[mg] = 1'b1;
    end
    if (chk) begin
      check_eq("grant", 32'(grant_o), 32'(eg));
      check_eq("m_valid", 32'(m_valid_o), 32'(ev));
      check_eq("m_data", 32'(m_data_o), 32'(ed));
      check_eq("s_ready", 32'(s_ready_o), 32'(esr));
      check_eq("busy", 32'(busy_o), 32'(mb));
`ifdef HS_ARB_CNT_EN
      check_eq("cnt", 32'(xfer_cnt_o), 32'(mcnt));
`endif
    end
    last_hs = (ev && m_ready_i) ? eg : '0;
    if (rst) begin
      mb   = 1'b0;
      mptr = N - 1;
      mcnt = 0;
    end else if (!mb) begin
      w = next_owner(s_valid_i, mptr);
      if (w >= 0) begin
        mb = 1'b1;
        mg = w;
      end
    end else if (!s_valid_i[mg]) begin
      mb = 1'b0;
    end else if (m_ready_i) begin
      total_hs++;
      if (!quiet) $display("xfer sender %0d data %02h (#%0d)", mg, ed, total_hs);
      mcnt = (mcnt + 1) % 65536;
      mptr = mg;
      mg   = next_owner(s_valid_i, mptr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    s_valid_i = '0;
    m_ready_i = 1'b0;
    cycle(1'b0);
    cycle(1'b0);
    rst = 1'b0;
  endtask

  logic [DW-1:0] held;

  initial begin
    rst       = 1'b1;
    s_valid_i = '0;
    s_data_i  = '0;
    m_ready_i = 1'b0;
    mb = 1'b0; mg = 0; mptr = N - 1; mcnt = 0; total_hs = 0; quiet = 1'b0;
    last_hs = '0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    check_eq("rst_grant", 32'(grant_o), 32'h0);
    check_eq("rst_mvalid", 32'(m_valid_o), 32'h0);
    check_eq("rst_sready", 32'(s_ready_o), 32'h0);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
    m_ready_i = 1'b1;
    cycle(1'b1);
    check_eq("idle_ready_no_grant", 32'(grant_o), 32'h0);

    // Single sender 2 with data A5
    s_data_i  = {8'h44, 8'hA5, 8'h22, 8'h11};
    s_valid_i = 4'b0100;
    cycle(1'b1);
    check_eq("single_grant", 32'(grant_o), 32'h4);
    check_eq("single_data", 32'(m_data_o), 32'hA5);
    check_eq("single_sready", 32'(s_ready_o), 32'h4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      check_eq("single_keep", 32'(grant_o), 32'h4);
    end

    // Fairness: all valid, receiver always ready
    do_reset();
    s_valid_i = 4'b1111;
    m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1);
      check_eq("fair_order", 32'(grant_o), 32'(1 << (i % N)));
      check_eq("fair_nobubble", 32'(m_valid_o), 32'h1);
    end

    // Stall on sender 1, then grant moves to 2
    do_reset();
    s_valid_i = 4'b0110;
    m_ready_i = 1'b0;
    cycle(1'b1);
    held = m_data_o;
    check_eq("stall_grant0", 32'(grant_o), 32'h2);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      check_eq("stall_grant", 32'(grant_o), 32'h2);
      check_eq("stall_data", 32'(m_data_o), 32'(held));
      check_eq("stall_sready", 32'(s_ready_o), 32'h0);
    end
    m_ready_i = 1'b1;
    cycle(1'b1);
    check_eq("stall_hs_count", 32'(mcnt), 32'h1);
    check_eq("stall_next", 32'(grant_o), 32'h4);

    // Withdraw: serve sender 1 to set ptr=1, then sender 3 withdraws
    do_reset();
    s_valid_i = 4'b0010;
    m_ready_i = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    s_valid_i = 4'b0000;
    cycle(1'b1);
    check_eq("wd_idle1", 32'(busy_o), 32'h0);
    s_valid_i = 4'b1000;
    m_ready_i = 1'b0;
    cycle(1'b1);
    check_eq("wd_grant3", 32'(grant_o), 32'h8);
    s_valid_i = 4'b0000;
    cycle(1'b1);
    check_eq("wd_idle_grant", 32'(grant_o), 32'h0);
    check_eq("wd_idle_busy", 32'(busy_o), 32'h0);
    s_valid_i = 4'b1001;
    cycle(1'b1);
    check_eq("wd_ptr_kept", 32'(grant_o), 32'h8);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (last_hs[k] || !s_valid_i[k]) begin
          s_valid_i[k] = 1'($urandom_range(0, 1));
          s_data_i[k*DW +: DW] = DW'($urandom);
        end else if ($urandom_range(0, 39) == 0) begin
          s_valid_i[k] = 1'b0;
        end
      end
      m_ready_i = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      cycle(1'b1);
    end
    rst = 1'b0;

`ifdef HS_ARB_CNT_EN
    // Counter wrap over 70000 handshakes, then reset mid-stream
    do_reset();
    quiet     = 1'b1;
    s_valid_i = 4'b0001;
    m_ready_i = 1'b1;
    total_hs  = 0;
    for (int c = 0; c < 70100 && total_hs < 70000; c++) begin
      cycle(1'b0);
    end
    check_eq("cnt_reached", 32'(total_hs), 32'd70000);
    check_eq("cnt_wrap", 32'(xfer_cnt_o), 32'd4464);
    rst = 1'b1;
    cycle(1'b0);
    rst = 1'b0;
    check_eq("cnt_rst", 32'(xfer_cnt_o), 32'd0);
    check_eq("cnt_rst_busy", 32'(busy_o), 32'd0);
    quiet = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
